// File: rtl/alu_bus_seq_pkg.sv
// Shared encodings for the ALU bus sequencer: FSM states, destination codes and op codes.
package alu_bus_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_DRIVE   = 3'd1;
  localparam state_t S_SETTLE  = 3'd2;
  localparam state_t S_CAPTURE = 3'd3;
  localparam state_t S_DONE    = 3'd4;

  localparam logic [1:0] DEST_A    = 2'd0;
  localparam logic [1:0] DEST_B    = 2'd1;
  localparam logic [1:0] DEST_OUT  = 2'd2;
  localparam logic [1:0] DEST_NONE = 2'd3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // The external ALU owns the data bus for the three middle states of a transaction.
  function automatic logic isBusDriven(input state_t s);
    return (s == S_DRIVE) || (s == S_SETTLE) || (s == S_CAPTURE);
  endfunction

endpackage

// File: rtl/alu_bus_seq_if.sv
// Connection between the sequencer (master) and the external ALU (slave).
interface alu_bus_seq_if;

  logic [7:0] areg;
  logic [7:0] breg;
  logic       doSubtract;
  logic       assertBarE;
  logic [7:0] dbus;
  logic       aluCout;

  modport master (
    output areg, breg, doSubtract, assertBarE,
    input  dbus, aluCout
  );

  modport slave (
    input  areg, breg, doSubtract, assertBarE,
    output dbus, aluCout
  );

endinterface

// File: rtl/alu_bus_seq.sv
// Sequencer that runs one add/subtract through an external ALU and writes the
// bus result back to A, B, OUT or nowhere, keeping carry/zero status.
module alu_bus_seq
  import alu_bus_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [1:0]       dest,
  input  logic             ldA,
  input  logic             ldB,
  input  logic [7:0]       ldData,
  alu_bus_seq_if.master    bus,
  output logic [7:0]       outReg,
  output logic             busy,
  output logic             done,
  output logic             flagCarry,
  output logic             flagZero
);

  state_t     state;
  logic [7:0] aReg;
  logic [7:0] bReg;
  logic       opLatched;
  logic [1:0] destLatched;

  // Operands only move in IDLE (external loads) or at the CAPTURE exit edge (write-back),
  // so the ALU sees stable inputs for the whole time it drives the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      aReg        <= 8'h00;
      bReg        <= 8'h00;
      outReg      <= 8'h00;
      flagCarry   <= 1'b0;
      flagZero    <= 1'b0;
      opLatched   <= OP_ADD;
      destLatched <= DEST_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opLatched   <= op;
            destLatched <= dest;
            state       <= S_DRIVE;
          end else begin
            if (ldA) aReg <= ldData;
            if (ldB) bReg <= ldData;
          end
        end
        S_DRIVE:  state <= S_SETTLE;
        S_SETTLE: state <= S_CAPTURE;
        S_CAPTURE: begin
          case (destLatched)
            DEST_A:   aReg   <= bus.dbus;
            DEST_B:   bReg   <= bus.dbus;
            DEST_OUT: outReg <= bus.dbus;
            default:  ;
          endcase
          flagCarry <= bus.aluCout;
          flagZero  <= (bus.dbus == 8'h00);
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Every output is decoded from registered state only.
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign bus.assertBarE = ~isBusDriven(state);
  assign bus.doSubtract = isBusDriven(state) & opLatched;
  assign bus.areg       = aReg;
  assign bus.breg       = bReg;

endmodule

// File: tb/tb_alu_bus_seq.sv
// Randomized scoreboard bench for alu_bus_seq with a bench-side ALU on the bus.
module tb_alu_bus_seq;
  import alu_bus_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [1:0] dest = 2'd0;
  logic       ldA = 1'b0;
  logic       ldB = 1'b0;
  logic [7:0] ldData = 8'h00;
  logic [7:0] outReg;
  logic       busy, done, flagCarry, flagZero;

  alu_bus_seq_if bus();

  alu_bus_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .dest(dest),
    .ldA(ldA), .ldB(ldB), .ldData(ldData), .bus(bus),
    .outReg(outReg), .busy(busy), .done(done),
    .flagCarry(flagCarry), .flagZero(flagZero)
  );

  always #5 clk = ~clk;

  // External ALU: drives the real sum when enabled, garbage otherwise.
  logic [7:0] junk = 8'h00;
  logic       junkC = 1'b0;
  logic [8:0] sum9;
  always @(negedge clk) begin
    junk  <= 8'($urandom);
    junkC <= 1'($urandom);
  end
  always_comb begin
    sum9 = bus.doSubtract ? ({1'b0, bus.areg} + {1'b0, ~bus.breg} + 9'd1)
                          : ({1'b0, bus.areg} + {1'b0, bus.breg});
    if (!bus.assertBarE) begin
      bus.dbus    = sum9[7:0];
      bus.aluCout = sum9[8];
    end else begin
      bus.dbus    = junk;
      bus.aluCout = junkC;
    end
  end

  typedef struct {
    int a; int b; int o; int c; int z;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int mA = 0, mB = 0, mOut = 0, mC = 0, mZ = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        checkOutput("sb_areg",   int'(bus.areg), e.a);
        checkOutput("sb_breg",   int'(bus.breg), e.b);
        checkOutput("sb_outReg", int'(outReg),   e.o);
        checkOutput("sb_carry",  int'(flagCarry), e.c);
        checkOutput("sb_zero",   int'(flagZero),  e.z);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; ldA = 1'b0; ldB = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mA = 0; mB = 0; mOut = 0; mC = 0; mZ = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_areg"},   int'(bus.areg), 0);
    checkOutput({tag, "_breg"},   int'(bus.breg), 0);
    checkOutput({tag, "_outReg"}, int'(outReg), 0);
    checkOutput({tag, "_carry"},  int'(flagCarry), 0);
    checkOutput({tag, "_zero"},   int'(flagZero), 0);
    checkOutput({tag, "_busy"},   int'(busy), 0);
    checkOutput({tag, "_done"},   int'(done), 0);
    checkOutput({tag, "_barE"},   int'(bus.assertBarE), 1);
    checkOutput({tag, "_doSub"},  int'(bus.doSubtract), 0);
  endtask

  task automatic loadRegs(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    ldA = 1'b1; ldData = a;
    @(negedge clk);
    ldA = 1'b0; ldB = 1'b1; ldData = b;
    @(negedge clk);
    ldB = 1'b0;
    mA = int'(a); mB = int'(b);
    checkOutput("load_areg", int'(bus.areg), mA);
    checkOutput("load_breg", int'(bus.breg), mB);
  endtask

  task automatic applyStimulus(input logic o, input logic [1:0] d,
                               input bit busyPoke, input bit dropLoad);
    int a0, b0, res, c;
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; dest = d;
    if (dropLoad) begin
      ldA = 1'b1; ldB = 1'b1; ldData = 8'h5A;
    end
    a0 = mA; b0 = mB;
    if (o) begin
      res = (mA - mB) & 255;
      c   = (mA >= mB) ? 1 : 0;
    end else begin
      res = (mA + mB) & 255;
      c   = (mA + mB > 255) ? 1 : 0;
    end
    case (d)
      2'd0: mA = res;
      2'd1: mB = res;
      2'd2: mOut = res;
      default: ;
    endcase
    mC = c;
    mZ = (res == 0) ? 1 : 0;
    e.a = mA; e.b = mB; e.o = mOut; e.c = mC; e.z = mZ;
    sbq.push_back(e);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start = 1'b0; ldA = 1'b0; ldB = 1'b0;
      checkOutput("txn_barE",  int'(bus.assertBarE), (cyc <= 3) ? 0 : 1);
      checkOutput("txn_doSub", int'(bus.doSubtract), (cyc <= 3) ? int'(o) : 0);
      checkOutput("txn_busy",  int'(busy), 1);
      checkOutput("txn_done",  int'(done), (cyc == 4) ? 1 : 0);
      if (cyc <= 3) begin
        checkOutput("txn_areg_stable", int'(bus.areg), a0);
        checkOutput("txn_breg_stable", int'(bus.breg), b0);
      end
      if (busyPoke && (cyc == 2 || cyc == 4)) begin
        start = 1'b1; ldA = 1'b1; ldData = 8'h99;
      end
    end
    @(negedge clk);
    start = 1'b0; ldA = 1'b0;
    checkOutput("post_busy", int'(busy), 0);
    checkOutput("post_done", int'(done), 0);
    checkOutput("post_areg", int'(bus.areg), mA);
  endtask

  initial begin
    doReset();
    checkResetState("rst0");

    // Simultaneous load of both registers with one value.
    @(negedge clk);
    ldA = 1'b1; ldB = 1'b1; ldData = 8'h3C;
    @(negedge clk);
    ldA = 1'b0; ldB = 1'b0;
    mA = 'h3C; mB = 'h3C;
    checkOutput("dual_load_areg", int'(bus.areg), 'h3C);
    checkOutput("dual_load_breg", int'(bus.breg), 'h3C);

    loadRegs(8'hAA, 8'h55);
    doReset();
    checkResetState("rst1");

    loadRegs(8'h12, 8'h34);
    applyStimulus(OP_ADD, DEST_OUT, 1'b0, 1'b0);
    loadRegs(8'h05, 8'h05);
    applyStimulus(OP_SUB, DEST_NONE, 1'b0, 1'b0);
    loadRegs(8'hF0, 8'h20);
    applyStimulus(OP_ADD, DEST_A, 1'b0, 1'b0);
    loadRegs(8'h21, 8'h43);
    applyStimulus(OP_ADD, DEST_OUT, 1'b1, 1'b0);
    loadRegs(8'h03, 8'h07);
    applyStimulus(OP_SUB, DEST_B, 1'b0, 1'b1);

    // Reset while the ALU is driving: transaction aborted, everything cleared.
    loadRegs(8'h11, 8'h22);
    @(negedge clk);
    start = 1'b1; op = OP_ADD; dest = DEST_OUT;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("abort_barE_settle", int'(bus.assertBarE), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mA = 0; mB = 0; mOut = 0; mC = 0; mZ = 0;
    checkResetState("abort");
    repeat (4) begin
      @(negedge clk);
      checkOutput("abort_no_done", int'(done), 0);
    end

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        loadRegs(8'($urandom), 8'($urandom));
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
